// File: rtl/sm_to_float_encoder_pkg.sv
// Shared types and default geometry for the sign-magnitude to compact-float encoder.
package float_enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned IN_WIDTH   = 12;
  localparam int unsigned EXP_WIDTH  = 3;
  localparam int unsigned MANT_WIDTH = 4;
  localparam int unsigned E_MAX      = 2**EXP_WIDTH - 1;
  localparam int unsigned C_INIT     = IN_WIDTH - MANT_WIDTH;

endpackage

// File: rtl/sm_to_float_encoder_round.sv
// Round-half-up of the truncated significand, with renormalise on carry-out
// and saturation at the largest exponent.
module float_round_unit #(
  parameter int unsigned EXP_WIDTH  = 3,
  parameter int unsigned MANT_WIDTH = 4
) (
  input  logic [MANT_WIDTH-1:0] t,
  input  logic                  r,
  input  logic [EXP_WIDTH:0]    c,
  output logic [MANT_WIDTH-1:0] f,
  output logic [EXP_WIDTH-1:0]  e
);

  localparam logic [EXP_WIDTH:0] E_TOP = {1'b0, {EXP_WIDTH{1'b1}}};

  logic [EXP_WIDTH:0] c_inc;

  assign c_inc = c + 1'b1;

  always_comb begin
    f = t;
    e = c[EXP_WIDTH-1:0];
    if (r) begin
      if (t != '1) begin
        f = t + 1'b1;
      end else if (c < E_TOP) begin
        // Carry out of the significand: 1111+1 = 10000 -> 1000 one octave up.
        f = {1'b1, {(MANT_WIDTH-1){1'b0}}};
        e = c_inc[EXP_WIDTH-1:0];
      end else begin
        f = '1;
        e = '1;
      end
    end
  end

endmodule

// File: rtl/sm_to_float_encoder.sv
// Serial normaliser: shifts the magnitude left one place per clock until the
// MSB is set or the exponent budget is spent, then rounds once.
module sm_to_float_encoder #(
  parameter int unsigned IN_WIDTH   = 12,
  parameter int unsigned EXP_WIDTH  = 3,
  parameter int unsigned MANT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  S,
  input  logic [IN_WIDTH-1:0]   SM,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  S_out,
  output logic [EXP_WIDTH-1:0]  E,
  output logic [MANT_WIDTH-1:0] F
);

  import float_enc_pkg::*;

  localparam logic [EXP_WIDTH:0] C_START = (EXP_WIDTH+1)'(IN_WIDTH - MANT_WIDTH);

  state_t                  state;
  logic [IN_WIDTH-1:0]     w;
  logic [EXP_WIDTH:0]      c;
  logic [MANT_WIDTH-1:0]   f_rnd;
  logic [EXP_WIDTH-1:0]    e_rnd;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  float_round_unit #(
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_round (
    .t (w[IN_WIDTH-1 -: MANT_WIDTH]),
    .r (w[IN_WIDTH-MANT_WIDTH-1]),
    .c (c),
    .f (f_rnd),
    .e (e_rnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      c     <= '0;
      S_out <= 1'b0;
      E     <= '0;
      F     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w     <= SM;
            c     <= C_START;
            S_out <= S;
            state <= NORM;
          end
        end
        NORM: begin
          if (w[IN_WIDTH-1] || (c == '0)) begin
            state <= ROUND;
          end else begin
            w <= w << 1;
            c <= c - 1'b1;
          end
        end
        ROUND: begin
          F     <= f_rnd;
          E     <= e_rnd;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_to_float_encoder.sv
// Directed and random conversions checked against an arithmetic rounding model.
module tb_sm_to_float_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [11:0] SM;
  logic        out_valid;
  logic        out_ready;
  logic        S_out;
  logic [2:0]  E;
  logic [3:0]  F;

  int vectors    = 0;
  int checks     = 0;
  int miscompares = 0;

  sm_to_float_encoder #(
    .IN_WIDTH   (12),
    .EXP_WIDTH  (3),
    .MANT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .SM        (SM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S_out     (S_out),
    .E         (E),
    .F         (F)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value model: find the MSB, divide by 2^(msb-3) rounding half up.
  function automatic void ref_conv(input logic [11:0] sm, output int e, output int f,
                                   output int lat);
    int p  = -1;
    int lz;
    int e0;
    int q;
    for (int i = 0; i < 12; i++) if (sm[i]) p = i;
    lz  = 11 - p;
    lat = ((lz < 8) ? lz : 8) + 3;
    if (p <= 3) begin
      e = 0;
      f = int'(sm);
    end else begin
      e0 = p - 3;
      q  = (int'(sm) + (1 << (e0 - 1))) >> e0;
      if (q == 16) begin
        if (e0 == 7) begin e = 7; f = 15; end
        else begin e = e0 + 1; f = 8; end
      end else begin
        e = e0;
        f = q;
      end
    end
  endfunction

  task automatic run_conv(input logic s, input logic [11:0] sm, input int bp, input bit early);
    int e_exp, f_exp, lat_exp, lat, waitc;
    logic [2:0] e_hold;
    logic [3:0] f_hold;
    ref_conv(sm, e_exp, f_exp, lat_exp);
    waitc = 0;
    while (!in_ready && waitc < 20) begin tick(); waitc++; end
    check("in_ready_before_accept", int'(in_ready), 1);
    out_ready = early;
    in_valid  = 1'b1;
    S         = s;
    SM        = sm;
    tick();
    in_valid  = 1'b0;
    vectors++;
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("latency", lat, lat_exp);
    check("out_valid", int'(out_valid), 1);
    check("in_ready_in_done", int'(in_ready), 0);
    check("S_out", int'(S_out), int'(s));
    check("E", int'(E), e_exp);
    check("F", int'(F), f_exp);
    e_hold = E;
    f_hold = F;
    if (!early) begin
      for (int k = 0; k < bp; k++) begin
        in_valid = 1'b1;
        S        = ~s;
        SM       = ~sm & 12'h7FF;
        tick();
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_E_stable", int'(E), int'(e_hold));
        check("bp_F_stable", int'(F), int'(f_hold));
        check("bp_S_stable", int'(S_out), int'(s));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("out_valid_dropped", int'(out_valid), 0);
    check("in_ready_after_take", int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    S         = 1'b1;
    SM        = 12'h123;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_E", int'(E), 0);
      check("rst_F", int'(F), 0);
      check("rst_S_out", int'(S_out), 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("idle_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_no_output", int'(out_valid), 0);
    end

    run_conv(1'b0, 12'h02C, 0, 1'b0);
    run_conv(1'b1, 12'h07E, 0, 1'b0);
    run_conv(1'b0, 12'h7FF, 0, 1'b0);
    run_conv(1'b1, 12'h000, 0, 1'b0);
    run_conv(1'b0, 12'h00F, 0, 1'b1);
    run_conv(1'b1, 12'h400, 5, 1'b0);
    run_conv(1'b0, 12'h7F0, 0, 1'b1);
    run_conv(1'b0, 12'h018, 1, 1'b0);

    // Abort in the third NORM cycle.
    in_valid = 1'b1;
    S        = 1'b1;
    SM       = 12'h001;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("abort_idle_ready", int'(in_ready), 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_no_output", int'(out_valid), 0);
    end
    run_conv(1'b0, 12'h100, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [11:0] r_sm;
      r_sm = 12'($urandom_range(0, 12'h7FF) >> $urandom_range(0, 10));
      run_conv(1'($urandom_range(0, 1)), r_sm, $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sm_to_float_encoder.md
Name: sm_to_float_encoder

Overview:
- Downstream stage of the two's-complement-to-sign-magnitude converter.
- Takes sign S plus 12-bit magnitude SM and produces compact float V = F * 2^E, with 3-bit exponent E and 4-bit significand F, rounded to nearest.
- Normalises serially, shifting one position per clock, under a valid/ready handshake on both sides.
- Sign bit passes through unchanged.

Parameters:
- IN_WIDTH, 12, magnitude width.
- EXP_WIDTH, 3, exponent width.
- MANT_WIDTH, 4, significand width.
- Legal only when IN_WIDTH == MANT_WIDTH + 2**EXP_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  S/SM valid.
- in_ready  output  1  block can accept a new value.
- S  input  1  sign from the upstream converter.
- SM  input  IN_WIDTH  magnitude; bit 11 is always 0 because upstream saturates.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- S_out  output  1  registered sign.
- E  output  EXP_WIDTH  exponent.
- F  output  MANT_WIDTH  significand.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE.
  - out_valid, S_out, E, F = 0.
  - Internal work register W = 0, counter C = 0.
  - in_ready = 0 while rst is high.
  - Reset mid-operation aborts the conversion with no output.
- States: IDLE, NORM, ROUND, DONE.
- in_ready = (state == IDLE) && !rst. It is combinational from state only, never from out_ready.
- IDLE:
  - On in_valid && in_ready: capture W <= SM, C <= 8 (IN_WIDTH-MANT_WIDTH), S_out <= S.
  - Next state NORM.
- NORM (one decision per cycle):
  - If W[11] == 1 or C == 0: go to ROUND.
  - Else: W <= W << 1 (zero fill), C <= C - 1.
  - Cycles in NORM = min(lz, 8) + 1, where lz = leading zeros of SM.
- ROUND (single cycle):
  - Truncated significand T = W[11:8]; round bit R = W[7]. Ties round up (plain round-half-up on R only).
  - R == 0: F <= T, E <= C.
  - R == 1 and T != 4'hF: F <= T + 1, E <= C.
  - R == 1, T == 4'hF, C < 7: F <= 4'b1000, E <= C + 1 (renormalise).
  - R == 1, T == 4'hF, C == 7: saturate, F <= 4'hF, E <= 7.
  - When C == 0, W[7] is a zero-filled bit, so no rounding occurs (denormal region, F = SM[3:0]).
  - Next state DONE.
- DONE:
  - out_valid = 1.
  - S_out, E, F held stable until out_ready.
  - On out_ready: out_valid drops next cycle, state returns to IDLE.
  - If out_ready is already high on entry, DONE lasts exactly one cycle.
- Throughput: one conversion in flight. No input is accepted until the prior result is taken.
- Latency from accept to out_valid: min(lz, 8) + 3 cycles.
  - 4 cycles for lz = 1.
  - 11 cycles for SM < 16.
- out_valid never asserts without a prior accepted input since reset.
- Arithmetic: C and E are unsigned. W is IN_WIDTH bits; shifted-out bits are discarded (always 0 by construction).
- SM = 0 gives E = 0, F = 0.

Decomposition:
- Shared package float_enc_pkg holds:
  - state enum (IDLE/NORM/ROUND/DONE);
  - constants IN_WIDTH, EXP_WIDTH, MANT_WIDTH, E_MAX = 2**EXP_WIDTH-1, C_INIT = IN_WIDTH-MANT_WIDTH.
- One natural sub-module: float_round_unit, a combinational block.
  - Inputs: T, R, C.
  - Outputs: rounded F and E with the renormalise and saturate rules.
  - Instantiated once in ROUND.
- FSM, W, C and handshake live in the top level.

Test Plan:
- Reset then idle: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, E=0, F=0. After release, in_ready=1 and no spurious output.
- Exact value: S=0, SM=0x02C (44) -> after 9 cycles, E=2, F=4'b1011 (11*4=44), S_out=0.
- Round with renormalise: S=1, SM=0x07E (126) -> E=4, F=4'b1000 (128), S_out=1, latency 8 cycles.
- Saturation: SM=0x7FF -> E=7, F=4'hF, latency 4 cycles. Also SM=0 -> E=0, F=0; SM=0x00F -> E=0, F=4'hF, latency 11.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> one-cycle acceptance, then IDLE with in_ready=1.
- Reset mid-NORM: accept SM=0x001, assert rst on 3rd NORM cycle -> IDLE, no out_valid. Next input SM=0x100 converts normally to E=5, F=4'b1000.
